// File: rtl/csr_access_unit.sv
// csr_access_unit
//   Initiator side of the CSR register-file ports. Executes one Zicsr
//   instruction (CSRRW/S/C and immediate forms) at a time: reads the old
//   value, computes the new one, issues at most one write, then returns the
//   old value for rd or flags an illegal access.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake from execute
//   req_funct3, req_csr        Zicsr funct3 and CSR address
//   req_rs1_val, req_rs1_idx   rs1 value, rs1 index (uimm for immediate forms)
//   req_rd_idx                 destination register index
//   csr_raddr, csr_rdata       read port (combinational read data)
//   csr_waddr, csr_wdata       write port
//   csr_web                    write enable, one-cycle pulse
//   rsp_valid/rsp_ready        response handshake
//   rsp_rd_idx, rsp_rd_data    rd index and old CSR value
//   rsp_rd_we, rsp_illegal     rd write enable, illegal-instruction flag
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request
// READ  | CSR read, new value / write-intent / illegal computed
// WRITE | one-cycle write pulse to the CSR file
// RESP  | response held until rsp_ready
module csr_access_unit #(
  parameter int XLEN       = 64,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [CSR_ADDR_W-1:0] req_csr,
  input  logic [XLEN-1:0]       req_rs1_val,
  input  logic [4:0]            req_rs1_idx,
  input  logic [4:0]            req_rd_idx,
  output logic [CSR_ADDR_W-1:0] csr_raddr,
  input  logic [XLEN-1:0]       csr_rdata,
  output logic [CSR_ADDR_W-1:0] csr_waddr,
  output logic [XLEN-1:0]       csr_wdata,
  output logic                  csr_web,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [4:0]            rsp_rd_idx,
  output logic [XLEN-1:0]       rsp_rd_data,
  output logic                  rsp_rd_we,
  output logic                  rsp_illegal
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [2:0]            funct3_q;
  logic [CSR_ADDR_W-1:0] csr_q;
  logic [XLEN-1:0]       rs1_val_q;
  logic [4:0]            rs1_idx_q;
  logic [4:0]            rd_idx_q;
  logic [XLEN-1:0]       old_q;
  logic [XLEN-1:0]       new_q;
  logic                  illegal_q;
  logic                  rd_we_q;

  logic [XLEN-1:0]       operand;
  logic [XLEN-1:0]       new_val;
  logic                  wr_intent;
  logic                  illegal;

  assign operand = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_val_q;

  always_comb begin
    new_val   = csr_rdata;
    wr_intent = 1'b0;
    case (funct3_q[1:0])
      2'b01: begin
        new_val   = operand;
        wr_intent = 1'b1;
      end
      2'b10: begin
        new_val   = csr_rdata | operand;
        wr_intent = (rs1_idx_q != 5'd0);
      end
      2'b11: begin
        new_val   = csr_rdata & ~operand;
        wr_intent = (rs1_idx_q != 5'd0);
      end
      default: begin
        new_val   = csr_rdata;
        wr_intent = 1'b0;
      end
    endcase
    // funct3 000/100 are not Zicsr; writes into the 0b11 space are read-only
    illegal = (funct3_q[1:0] == 2'b00) ||
              (wr_intent && (csr_q[CSR_ADDR_W-1:CSR_ADDR_W-2] == 2'b11));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_READ;
      S_READ:  state_d = (wr_intent && !illegal) ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      funct3_q  <= 3'd0;
      csr_q     <= '0;
      rs1_val_q <= '0;
      rs1_idx_q <= 5'd0;
      rd_idx_q  <= 5'd0;
      old_q     <= '0;
      new_q     <= '0;
      illegal_q <= 1'b0;
      rd_we_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) begin
        funct3_q  <= req_funct3;
        csr_q     <= req_csr;
        rs1_val_q <= req_rs1_val;
        rs1_idx_q <= req_rs1_idx;
        rd_idx_q  <= req_rd_idx;
      end
      if (state_q == S_READ) begin
        old_q     <= csr_rdata;
        new_q     <= new_val;
        illegal_q <= illegal;
        rd_we_q   <= !illegal && (rd_idx_q != 5'd0);
      end
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  assign req_ready   = (state_q == S_IDLE);
  assign csr_raddr   = csr_q;
  assign csr_waddr   = csr_q;
  assign csr_wdata   = new_q;
  assign csr_web     = (state_q == S_WRITE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_rd_idx  = rd_idx_q;
  assign rsp_rd_data = old_q;
  assign rsp_rd_we   = rd_we_q;
  assign rsp_illegal = illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr;
  logic [63:0] req_rs1_val;
  logic [4:0]  req_rs1_idx;
  logic [4:0]  req_rd_idx;
  logic [11:0] csr_raddr;
  logic [63:0] csr_rdata;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        csr_web;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd_idx;
  logic [63:0] rsp_rd_data;
  logic        rsp_rd_we;
  logic        rsp_illegal;

  csr_access_unit #(.XLEN(64), .CSR_ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_csr(req_csr),
    .req_rs1_val(req_rs1_val), .req_rs1_idx(req_rs1_idx), .req_rd_idx(req_rd_idx),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_web(csr_web),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd_idx(rsp_rd_idx), .rsp_rd_data(rsp_rd_data),
    .rsp_rd_we(rsp_rd_we), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // CSR file environment and the bench's own reference copy of it
  logic [63:0] mem   [0:4095];
  logic [63:0] model [0:4095];

  assign csr_rdata = mem[csr_raddr];
  always @(posedge clk) if (csr_web) mem[csr_waddr] <= csr_wdata;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
    int          cyc;
  } wr_exp_t;

  typedef struct {
    logic [4:0]  rd_idx;
    logic [63:0] rd_data;
    logic        rd_we;
    logic        ill;
    int          start;
  } rsp_exp_t;

  wr_exp_t  wq[$];
  rsp_exp_t rq[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Response / write monitor
  logic        in_rsp = 1'b0;
  logic [4:0]  h_idx;
  logic [63:0] h_data;
  logic        h_we, h_ill;

  always @(negedge clk) begin
    wr_exp_t  w;
    rsp_exp_t e;
    if (rst_n) begin
      if (csr_web) begin
        if (wq.size() == 0) chk("web_unexpected", csr_web, 0);
        else begin
          w = wq.pop_front();
          chk("waddr", csr_waddr, w.addr);
          chk("wdata", csr_wdata, w.data);
          chk("web_cycle", cyc, w.cyc);
        end
      end
      if (rsp_valid) begin
        if (!in_rsp) begin
          if (rq.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
          else begin
            e = rq.pop_front();
            chk("rsp_rd_idx", rsp_rd_idx, e.rd_idx);
            chk("rsp_rd_data", rsp_rd_data, e.rd_data);
            chk("rsp_rd_we", rsp_rd_we, e.rd_we);
            chk("rsp_illegal", rsp_illegal, e.ill);
            chk("rsp_cycle", cyc, e.start);
          end
          h_idx = rsp_rd_idx; h_data = rsp_rd_data; h_we = rsp_rd_we; h_ill = rsp_illegal;
          in_rsp = 1'b1;
        end else begin
          chk("hold_idx", rsp_rd_idx, h_idx);
          chk("hold_data", rsp_rd_data, h_data);
          chk("hold_we", rsp_rd_we, h_we);
          chk("hold_ill", rsp_illegal, h_ill);
        end
        chk("ready_in_resp", req_ready, 0);
        if (rsp_ready) in_rsp = 1'b0;
      end
    end
  end

  task automatic do_req(input logic [2:0] f3, input logic [11:0] csr,
                        input logic [63:0] v, input logic [4:0] idx, input logic [4:0] rd);
    logic [63:0] op, old, nv;
    logic        wi, ill;
    int          n, acc;
    wr_exp_t     w;
    rsp_exp_t    e;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_ready", req_ready, 1);
    old = model[csr];
    op  = f3[2] ? {59'd0, idx} : v;
    case (f3[1:0])
      2'b01:   nv = op;
      2'b10:   nv = old | op;
      2'b11:   nv = old & ~op;
      default: nv = old;
    endcase
    wi  = (f3[1:0] == 2'b01) || (idx != 5'd0);
    ill = (f3[1:0] == 2'b00) || (wi && csr[11:10] == 2'b11);
    req_valid = 1'b1; req_funct3 = f3; req_csr = csr;
    req_rs1_val = v; req_rs1_idx = idx; req_rd_idx = rd;
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
    if (wi && !ill) begin
      w.addr = csr; w.data = nv; w.cyc = acc + 1;
      wq.push_back(w);
      model[csr] = nv;
    end
    e.rd_idx = rd; e.rd_data = old; e.rd_we = !ill && (rd != 5'd0); e.ill = ill;
    e.start = (wi && !ill) ? acc + 2 : acc + 1;
    rq.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((rq.size() != 0 || in_rsp) && n < 100) begin @(posedge clk); n++; end
    #1;
    chk("done_in_time", (n < 100), 1);
    chk("write_drained", wq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [63:0] saved;
    for (int i = 0; i < 4096; i++) begin mem[i] = 64'd0; model[i] = 64'd0; end
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_funct3 = 3'd0; req_csr = 12'd0; req_rs1_val = 64'd0;
    req_rs1_idx = 5'd0; req_rd_idx = 5'd0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_web", csr_web, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rd_we", rsp_rd_we, 0);
    chk("rst_illegal", rsp_illegal, 0);
    chk("rst_raddr", csr_raddr, 0);
    chk("rst_wdata", csr_wdata, 0);
    chk("rst_rd_data", rsp_rd_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(3'b001, 12'h340, 64'h1234, 5'd7, 5'd5);  wait_done();  // CSRRW
    do_req(3'b010, 12'h340, 64'h00F0, 5'd3, 5'd6);  wait_done();  // CSRRS
    do_req(3'b111, 12'h340, 64'hFFFF, 5'd4, 5'd7);  wait_done();  // CSRRCI
    do_req(3'b010, 12'h340, 64'hFFFF, 5'd0, 5'd8);  wait_done();  // CSRRS x0, no write
    do_req(3'b001, 12'hF14, 64'h55,   5'd1, 5'd9);  wait_done();  // write RO: illegal
    do_req(3'b010, 12'hF14, 64'h0,    5'd0, 5'd10); wait_done();  // read RO: legal
    do_req(3'b100, 12'h340, 64'h1,    5'd1, 5'd11); wait_done();  // funct3 100
    do_req(3'b000, 12'h340, 64'h1,    5'd0, 5'd12); wait_done();  // funct3 000
    do_req(3'b101, 12'h341, 64'h0,    5'd31, 5'd0); wait_done();  // CSRRWI, rd=0
    do_req(3'b110, 12'hC00, 64'h0,    5'd0, 5'd13); wait_done();  // CSRRSI 0 on RO
    do_req(3'b011, 12'hC00, 64'h0,    5'd2, 5'd14); wait_done();  // CSRRC on RO: illegal
    do_req(3'b011, 12'h341, 64'h3,    5'd2, 5'd15); wait_done();  // CSRRC 0x1F & ~3

    // Backpressure, then a back-to-back request right after the handshake
    rsp_ready = 1'b0;
    do_req(3'b010, 12'h340, 64'h0, 5'd0, 5'd9);
    n = 0;
    while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("bp_valid", rsp_valid, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b_ready", req_ready, 1);
    do_req(3'b001, 12'h342, 64'hABCD, 5'd4, 5'd3);
    wait_done();

    // Reset in the middle of a write cycle
    saved = model[12'h340];
    do_req(3'b001, 12'h340, 64'hDEAD, 5'd1, 5'd2);
    n = 0;
    do begin @(negedge clk); n++; end while (!csr_web && n < 10);
    chk("mid_web_seen", csr_web, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_web", csr_web, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_req_ready", req_ready, 1);
    chk("mr_waddr", csr_waddr, 0);
    chk("mr_wdata", csr_wdata, 0);
    chk("mr_rd_idx", rsp_rd_idx, 0);
    chk("mr_rd_data", rsp_rd_data, 0);
    chk("mr_rd_we", rsp_rd_we, 0);
    chk("mr_illegal", rsp_illegal, 0);
    rq.delete();
    wq.delete();
    model[12'h340] = saved;
    @(posedge clk); #1;
    chk("mr_csr_kept", mem[12'h340], saved);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("mr_no_rsp", rsp_valid, 0);
    end
    do_req(3'b010, 12'h340, 64'h0, 5'd0, 5'd1);  wait_done();  // read back

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
